// File: rtl/pipeline_hazard_controller.sv
// Register scoreboard and hold sequencer for the read stage: counts in-flight
// writes per register, stalls reads of pending sources, and flushes on PC retire.
module pipeline_hazard_controller #(
  parameter int NR = 4,
  parameter int CW = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          read_valid,
  input  logic [4:0]    read_left,
  input  logic [4:0]    read_right,
  input  logic          read_right_is_memory,
  input  logic [4:0]    read_destination,
  input  logic          read_destination_is_memory,
  input  logic          write_valid,
  input  logic [4:0]    write_destination,
  input  logic          write_destination_is_memory,
  output logic          read_hold,
  output logic          flush,
  output logic [NR-1:0] pending,
  output logic          underflow_error
);

  localparam logic [4:0]    PC_IDX  = 5'(NR - 2);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] r_cnt [NR];
  logic          r_flush;
  logic          r_underflow;

  logic [CW-1:0] w_cnt_nxt [NR];
  logic [NR-1:0] w_pend;
  logic [NR-1:0] w_inc;
  logic [NR-1:0] w_dec;
  logic          w_hazard;
  logic          w_dest_full;
  logic          w_dest_counted;
  logic          w_issue;
  logic          w_retire;
  logic          w_pc_retire;
  logic          w_underflow;

  // Out-of-range indices alias register 0, which is never counted.
  function automatic logic f_counted(input logic [4:0] idx, input logic is_mem);
    return !is_mem && (idx != 5'd0) && (int'(idx) < NR);
  endfunction

  // Per-register pending flags straight from the counters.
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < NR; i++) begin
      w_pend[i] = (i != 0) && (r_cnt[i] != {CW{1'b0}});
    end
  end

  // Hold decision: source hazards (PC and r0 excluded), full destination counter, flush.
  always_comb begin
    w_dest_counted = f_counted(read_destination, read_destination_is_memory);
    w_hazard       = 1'b0;
    w_dest_full    = 1'b0;
    for (int i = 1; i < NR; i++) begin
      w_hazard    = w_hazard | ((i != NR - 2) && w_pend[i] &&
                    ((read_left == 5'(i)) || (read_right == 5'(i))));
      w_dest_full = w_dest_full | (w_dest_counted && (read_destination == 5'(i)) &&
                    (r_cnt[i] == CNT_MAX));
    end
    read_hold = (read_valid & w_hazard) | w_dest_full | r_flush;
  end

  // Issue and retire strobes per register.
  always_comb begin
    w_issue     = read_valid & ~read_hold & w_dest_counted;
    w_retire    = write_valid & f_counted(write_destination, write_destination_is_memory);
    w_pc_retire = w_retire & (write_destination == PC_IDX);
    w_inc       = '0;
    w_dec       = '0;
    for (int i = 0; i < NR; i++) begin
      w_inc[i] = w_issue & (read_destination == 5'(i));
      w_dec[i] = w_retire & (write_destination == 5'(i));
    end
    w_underflow = |(w_dec & ~w_pend);
  end

  // Counter next-state; a PC retire wipes everything including same-cycle updates.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_pc_retire) begin
        w_cnt_nxt[i] = {CW{1'b0}};
      end else if (w_inc[i] && w_dec[i]) begin
        w_cnt_nxt[i] = r_cnt[i];
      end else if (w_inc[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
      end else if (w_dec[i] && w_pend[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // State registers: counters, flush pulse, sticky underflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) begin
        r_cnt[i] <= {CW{1'b0}};
      end
      r_flush     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_flush     <= w_pc_retire;
      r_underflow <= r_underflow | w_underflow;
    end
  end

  assign flush           = r_flush;
  assign pending         = w_pend;
  assign underflow_error = r_underflow;

endmodule
